// File: rtl/verify_tx.sv
// verify_tx: captures the EPROM data bus once per qualified read phase and
// echoes every captured byte out of a UART 8N1 transmitter.
//
// Parameters:
//   CLK_HZ        system clock frequency in Hz
//   BAUD          UART line rate; bit period DIV = CLK_HZ / BAUD cycles
//   SETTLE_CYCLES cycles from the qualified-read edge to the bus sample (>= 1)
//   FIFO_DEPTH    captured-byte buffer depth (power of two, >= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rdy        in   read-phase ready from the programmer stage
//   tx_block   in   high while the programmer latches an address
//   bus_in     in   [7:0] EPROM data bus
//   tx_busy    out  byte queued, frame in flight or capture settling
//   txd        out  UART serial output, idle high, registered
//   byte_count out  [10:0] captured bytes, modulo 2048
//   overflow   out  sticky, a captured byte was dropped on a full FIFO
//
// Optional feature: define VERIFY_CHECKSUM_EN to keep a running 8-bit sum of
// captured bytes and transmit it as an extra frame every 2048 captures.
`timescale 1ns/1ps

module verify_tx #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned SETTLE_CYCLES = 5,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        tx_block,
    input  logic [7:0]  bus_in,
    output logic        tx_busy,
    output logic        txd,
    output logic [10:0] byte_count,
    output logic        overflow
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PTR_W:0]     FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]   TICK_LAST = DIV_W'(DIV - 1);
    localparam logic [SET_W-1:0]   SETTLE_LD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    // ---------------- capture ----------------
    logic             q, q_d, armed;
    logic             settle_act;
    logic [SET_W-1:0] settle_cnt;
    logic             push;

    assign q = rdy & ~tx_block;

    // armed stays low until q has been seen low after reset, so a read phase
    // already in progress at reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_d        <= 1'b0;
            armed      <= 1'b0;
            settle_act <= 1'b0;
            settle_cnt <= '0;
        end else begin
            q_d <= q;
            if (!q) armed <= 1'b1;
            if (settle_act) begin
                if (!q || settle_cnt == SET_W'(1)) settle_act <= 1'b0;
                else                               settle_cnt <= settle_cnt - SET_W'(1);
            end else if (q && !q_d && armed) begin
                settle_act <= 1'b1;
                settle_cnt <= SETTLE_LD;
            end
        end
    end

    assign push = settle_act & q & (settle_cnt == SET_W'(1));

    // ---------------- FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill;
    logic             fifo_empty, fifo_full, push_ok, pop;

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL_LVL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: fill <= fill;
            endcase
            if (push) byte_count <= byte_count + 11'd1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // ---------------- transmit source select ----------------
    logic       src_valid;
    logic [7:0] src_data;
    logic       load;

`ifdef VERIFY_CHECKSUM_EN
    logic [7:0] run_sum, cks_val;
    logic       cks_pend;

    // The 2048th byte is folded into the latched value, not the new sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sum  <= '0;
            cks_val  <= '0;
            cks_pend <= 1'b0;
        end else begin
            if (load && cks_pend) cks_pend <= 1'b0;
            if (push) begin
                if (byte_count == 11'h7FF) begin
                    cks_val  <= run_sum + bus_in;
                    cks_pend <= 1'b1;
                    run_sum  <= '0;
                end else begin
                    run_sum <= run_sum + bus_in;
                end
            end
        end
    end

    assign src_valid = cks_pend | ~fifo_empty;
    assign src_data  = cks_pend ? cks_val : mem[rd_ptr];
    assign pop       = load & ~cks_pend;
`else
    assign src_valid = ~fifo_empty;
    assign src_data  = mem[rd_ptr];
    assign pop       = load;
`endif

    // ---------------- serializer ----------------
    tx_state_t        state, state_nx;
    logic [DIV_W-1:0] tick, tick_nx;
    logic [2:0]       bit_idx, bit_nx;
    logic [7:0]       shreg, sh_nx;
    logic             txd_nx;
    logic             tick_wrap;

    assign tick_wrap = (tick == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_idx <= bit_nx;
            shreg   <= sh_nx;
            txd     <= txd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick + DIV_W'(1);
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        txd_nx   = txd;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                tick_nx = '0;
                txd_nx  = 1'b1;
                if (src_valid) begin
                    load     = 1'b1;
                    sh_nx    = src_data;
                    txd_nx   = 1'b0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (tick_wrap) begin
                    tick_nx  = '0;
                    bit_nx   = '0;
                    txd_nx   = shreg[0];
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_wrap) begin
                    tick_nx = '0;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = S_STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                        sh_nx  = shreg >> 1;
                        txd_nx = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (tick_wrap) begin
                    tick_nx  = '0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef VERIFY_CHECKSUM_EN
    assign tx_busy = src_valid | (state != S_IDLE) | settle_act;
`else
    assign tx_busy = ~fifo_empty | (state != S_IDLE) | settle_act;
`endif

endmodule

// File: tb/tb_verify_tx.sv
`timescale 1ns/1ps

module tb_verify_tx;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int DIV    = 10;
    localparam int SETTLE = 5;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 10 * DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        tx_block = 1'b0;
    logic [7:0]  bus_in = '0;
    logic        tx_busy, txd, overflow;
    logic [10:0] byte_count;

    verify_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .SETTLE_CYCLES(SETTLE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .tx_block(tx_block),
        .bus_in(bus_in),
        .tx_busy(tx_busy),
        .txd(txd),
        .byte_count(byte_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        int         pop;
    } exp_t;

    exp_t sb_q[$];
    int   pend_pops[$];
    int   model_count;
    bit   model_ovf;
    int   last_pop;

    function automatic void model_reset();
        sb_q.delete();
        pend_pops.delete();
        model_count = 0;
        model_ovf   = 1'b0;
        last_pop    = -1000000;
    endfunction

    // A byte pushed at edge p is held if fewer than DEPTH accepted bytes are
    // still waiting (their frame starts after p). Frames start one cycle after
    // the push, or FRAME cycles after the previous frame start.
    function automatic void model_push(input logic [7:0] d, input int p);
        int occ;
        int pp;
        occ = 0;
        model_count = (model_count + 1) % 2048;
        foreach (pend_pops[i]) if (pend_pops[i] > p) occ++;
        if (occ < DEPTH) begin
            pp = (last_pop + FRAME > p + 1) ? last_pop + FRAME : p + 1;
            last_pop = pp;
            pend_pops.push_back(pp);
            sb_q.push_back('{data: d, pop: pp});
        end else begin
            model_ovf = 1'b1;
        end
    endfunction

    // ---------------- serial monitor ----------------
    bit         in_frame = 1'b0;
    bit         prev_txd = 1'b1;
    bit         fexp_valid = 1'b0;
    int         fstart;
    int         rel;
    logic [9:0] fbits;
    logic [7:0] fexp;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
            prev_txd = 1'b1;
        end else begin
            if (!in_frame) begin
                if (prev_txd && !txd) begin
                    in_frame = 1'b1;
                    fstart   = cyc;
                    fbits    = '0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame: frame start at cycle %0d, expected none", cyc);
                        fexp_valid = 1'b0;
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("frame_start_cycle", cyc, mon_e.pop);
                        fexp       = mon_e.data;
                        fexp_valid = 1'b1;
                    end
                end
            end else begin
                rel = cyc - fstart;
                if (rel % DIV == DIV / 2) fbits[rel / DIV] = txd;
                if (rel == 9 * DIV + DIV / 2) begin
                    in_frame = 1'b0;
                    if (fexp_valid) check("frame_bits", int'(fbits), int'({1'b1, fexp, 1'b0}));
                end
            end
            prev_txd = txd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic capture(input logic [7:0] d, input int hold, input bit via_block);
        int x;
        @(negedge clk);
        bus_in = d;
        rdy    = 1'b1;
        x      = cyc;
        repeat (hold) @(negedge clk);
        if (via_block) begin
            tx_block = 1'b1;
            @(negedge clk);
            rdy      = 1'b0;
            tx_block = 1'b0;
        end else begin
            rdy = 1'b0;
        end
        bus_in = ~d;
        if (hold == SETTLE + 1) model_push(d, x + SETTLE + 1);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((tx_busy || sb_q.size() != 0 || in_frame) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n >= max_cyc), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int x;
        int target;
        int fs;
        logic [7:0] d;
        model_reset();

        // reset values
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", byte_count, 0);
        check("rst_ovf", overflow, 0);

        // q already high at reset release: no capture
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("q_high_release_count", byte_count, model_count);
        check("q_high_release_busy", tx_busy, 0);
        rdy = 1'b0;
        repeat (2) @(negedge clk);

        // single capture of A5
        bus_in = 8'hA5;
        rdy    = 1'b1;
        x      = cyc;
        @(negedge clk);
        check("settle_busy", tx_busy, 1);
        repeat (SETTLE) @(negedge clk);
        model_push(8'hA5, x + SETTLE + 1);
        rdy    = 1'b0;
        bus_in = 8'h5A;
        check("count_after_push", byte_count, model_count);
        drain(2000);
        check("count_single", byte_count, 1);

        // abandoned captures: rdy drops early, tx_block rises on the last settle cycle
        capture(8'h77, 3, 1'b0);
        capture(8'h66, SETTLE, 1'b1);
        repeat (3) @(negedge clk);
        check("abandon_count", byte_count, model_count);
        check("abandon_busy", tx_busy, 0);

        // full FIFO with push landing on a pop edge
        for (int i = 0; i < 5; i++) capture(8'h10 + 8'(i), SETTLE + 1, 1'b0);
        target = (sb_q.size() > 0) ? sb_q[0].pop : cyc + 1000;
        while (cyc < target - SETTLE - 2) @(negedge clk);
        capture(8'h20, SETTLE + 1, 1'b0);
        check("full_push_pop_ovf", overflow, int'(model_ovf));
        check("full_push_pop_count", byte_count, model_count);
        drain(3000);

        // randomized captures
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 60)) @(negedge clk);
            if ($urandom_range(0, 5) == 0)
                capture(d, $urandom_range(1, SETTLE), 1'($urandom_range(0, 1)));
            else
                capture(d, SETTLE + 1, 1'b0);
        end
        drain(5000);
        check("random_count", byte_count, model_count);
        check("random_ovf", overflow, int'(model_ovf));

        // reset during data bit 3 of a frame
        capture(8'hF0, SETTLE + 1, 1'b0);
        fs = last_pop;
        while (cyc < fs + 4 * DIV + 3) @(negedge clk);
        check("pre_reset_txd", txd, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_count", byte_count, 0);
        check("mid_rst_ovf", overflow, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3 * FRAME) @(negedge clk);
        check("post_rst_count", byte_count, model_count);
        check("post_rst_busy", tx_busy, 0);

        // six rapid captures: sixth is dropped
        for (int i = 1; i <= 6; i++) capture(8'(i), SETTLE + 1, 1'b0);
        check("rapid_ovf", overflow, int'(model_ovf));
        check("rapid_count", byte_count, model_count);
        drain(3000);
        check("rapid_ovf_sticky", overflow, int'(model_ovf));
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
